// File: rtl/regfile_wb_scheduler_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler_if
//
// Purpose:
//   Bundles the signals between the writeback scheduler and its neighbours:
//   the issue stage, the hazard query, the ALU/CSR and LSU writeback sources,
//   and the register-file write port.
//
// Modports:
//   slave  - the scheduler itself. It receives issue/query/writeback requests
//            and drives ready, hazard and the register-file write port.
//   master - the surrounding pipeline, or a testbench driver.
//
// Signal summary:
//   issue_valid/issue_rd/issue_ready  destination-register issue handshake
//   rs1/rs2/hazard                    RAW hazard query on the source registers
//   alu_valid/alu_ready/alu_rd/alu_data  ALU/CSR writeback handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  LSU writeback handshake
//   rf_wen/rf_waddr/rf_wdata          registered register-file write port
// -----------------------------------------------------------------------------
interface regfile_wb_scheduler_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);

   logic                  issue_valid;
   logic [ADDR_WIDTH-1:0] issue_rd;
   logic                  issue_ready;

   logic [ADDR_WIDTH-1:0] rs1;
   logic [ADDR_WIDTH-1:0] rs2;
   logic                  hazard;

   logic                  alu_valid;
   logic                  alu_ready;
   logic [ADDR_WIDTH-1:0] alu_rd;
   logic [DATA_WIDTH-1:0] alu_data;

   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [ADDR_WIDTH-1:0] lsu_rd;
   logic [DATA_WIDTH-1:0] lsu_data;

   logic                  rf_wen;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;

   modport slave (
      input  issue_valid, issue_rd,
      output issue_ready,
      input  rs1, rs2,
      output hazard,
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready,
      output rf_wen, rf_waddr, rf_wdata
   );

   modport master (
      output issue_valid, issue_rd,
      input  issue_ready,
      output rs1, rs2,
      input  hazard,
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready,
      input  rf_wen, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Purpose:
//   Shares the single register-file write port between the ALU/CSR writeback
//   source and the LSU writeback source, and keeps a busy-bit scoreboard of
//   destination registers with outstanding writes so the issue stage can stall
//   on RAW (hazard) and WAW (issue_ready) conflicts.
//
//   Each source owns a one-entry holding buffer. The arbiter grants a full
//   buffer to the write port each cycle, alternating between the two sources
//   when both are full. The write port (rf_wen/rf_waddr/rf_wdata) is driven
//   straight from registers, so a writeback accepted at edge E appears on
//   rf_wen after E+1 and lands in the register file at E+2. The busy bit of a
//   register is cleared on that same E+2 edge.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - asynchronous reset, active low
//   flush  - synchronous pipeline flush; drops the scoreboard and both
//            holding buffers
//   bus    - regfile_wb_scheduler_if.slave: issue handshake, hazard query,
//            ALU and LSU writeback handshakes, register-file write port
// -----------------------------------------------------------------------------
module regfile_wb_scheduler #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   regfile_wb_scheduler_if.slave  bus
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } src_t;

   logic [NUM_REGS-1:0]   busy;
   logic [NUM_REGS-1:0]   busy_next;

   logic                  alu_full;
   logic [ADDR_WIDTH-1:0] alu_rd_q;
   logic [DATA_WIDTH-1:0] alu_data_q;

   logic                  lsu_full;
   logic [ADDR_WIDTH-1:0] lsu_rd_q;
   logic [DATA_WIDTH-1:0] lsu_data_q;

   src_t                  last_grant;

   logic                  grant_alu;
   logic                  grant_lsu;
   logic                  alu_ready;
   logic                  lsu_ready;
   logic                  alu_load;
   logic                  lsu_load;
   logic                  issue_ready;
   logic                  issue_set;

   logic                  rf_wen_q;
   logic [ADDR_WIDTH-1:0] rf_waddr_q;
   logic [DATA_WIDTH-1:0] rf_wdata_q;

   // Arbiter: a lone full buffer always wins; with both full the source that
   // did not win last time goes next, which gives strict alternation under
   // continuous load from both sides.
   assign grant_alu = alu_full && (!lsu_full || (last_grant == SRC_LSU));
   assign grant_lsu = lsu_full && (!alu_full || (last_grant == SRC_ALU));

   // A buffer can accept while it is being drained, so a single source can
   // stream one write per cycle.
   assign alu_ready = !alu_full || grant_alu;
   assign lsu_ready = !lsu_full || grant_lsu;

   // Writebacks to x0 complete the handshake but are never buffered.
   assign alu_load = bus.alu_valid && alu_ready && (bus.alu_rd != '0);
   assign lsu_load = bus.lsu_valid && lsu_ready && (bus.lsu_rd != '0);

   // WAW check: an instruction may not claim a destination that still has a
   // write outstanding. x0 never becomes busy.
   assign issue_ready = !((bus.issue_rd != '0) && busy[bus.issue_rd]);
   assign issue_set   = bus.issue_valid && issue_ready && (bus.issue_rd != '0);

   assign bus.issue_ready = issue_ready;
   assign bus.alu_ready   = alu_ready;
   assign bus.lsu_ready   = lsu_ready;

   // RAW query looks only at the scoreboard; there is no bypass from the
   // holding buffers or the write port.
   assign bus.hazard = ((bus.rs1 != '0) && busy[bus.rs1]) ||
                       ((bus.rs2 != '0) && busy[bus.rs2]);

   assign bus.rf_wen   = rf_wen_q;
   assign bus.rf_waddr = rf_waddr_q;
   assign bus.rf_wdata = rf_wdata_q;

   // Next scoreboard value. The register being written this cycle is released
   // on the same edge the register file captures it. The set is applied after
   // the clear so that, if a fresh issue ever targets the register being
   // written, the newer outstanding write keeps the bit held.
   always_comb begin
      busy_next = busy;
      if (rf_wen_q) begin
         busy_next[rf_waddr_q] = 1'b0;
      end
      if (issue_set) begin
         busy_next[bus.issue_rd] = 1'b1;
      end
   end

   // Scoreboard register. Flush drops every outstanding claim, including any
   // issue presented in the flush cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // ALU holding buffer. Loading takes priority over draining so a granted
   // entry can be replaced by the next one on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_full   <= 1'b0;
         alu_rd_q   <= '0;
         alu_data_q <= '0;
      end else if (flush) begin
         alu_full <= 1'b0;
      end else if (alu_load) begin
         alu_full   <= 1'b1;
         alu_rd_q   <= bus.alu_rd;
         alu_data_q <= bus.alu_data;
      end else if (grant_alu) begin
         alu_full <= 1'b0;
      end
   end

   // LSU holding buffer, same behaviour as the ALU one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lsu_full   <= 1'b0;
         lsu_rd_q   <= '0;
         lsu_data_q <= '0;
      end else if (flush) begin
         lsu_full <= 1'b0;
      end else if (lsu_load) begin
         lsu_full   <= 1'b1;
         lsu_rd_q   <= bus.lsu_rd;
         lsu_data_q <= bus.lsu_data;
      end else if (grant_lsu) begin
         lsu_full <= 1'b0;
      end
   end

   // Register-file write port and round-robin history. Reset leaves the LSU
   // as the last winner so the ALU takes the first tie. When nothing is
   // granted only the enable drops; address and data keep their last values.
   // A write already on the port during a flush still reaches the register
   // file; only the following cycle is suppressed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         last_grant <= SRC_LSU;
      end else if (flush) begin
         rf_wen_q <= 1'b0;
      end else if (grant_alu) begin
         rf_wen_q   <= 1'b1;
         rf_waddr_q <= alu_rd_q;
         rf_wdata_q <= alu_data_q;
         last_grant <= SRC_ALU;
      end else if (grant_lsu) begin
         rf_wen_q   <= 1'b1;
         rf_waddr_q <= lsu_rd_q;
         rf_wdata_q <= lsu_data_q;
         last_grant <= SRC_LSU;
      end else begin
         rf_wen_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//
// Drives the scheduler through directed scenarios followed by random traffic.
// A reference model held in queues and arrays predicts ready/hazard each cycle
// and pushes each expected register-file write, stamped with the cycle it must
// appear in, onto a scoreboard. An independent monitor pops and compares after
// every rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2 ** AW;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;

   regfile_wb_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   regfile_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            stamp;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   // Reference model state
   wr_t           exp_q[$];
   ent_t          alu_pend[$];
   ent_t          lsu_pend[$];
   bit            m_busy[NR];
   bit            last_was_alu;
   bit            m_wr_valid;
   logic [AW-1:0] m_wr_rd;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic modelReset();
      alu_pend.delete();
      lsu_pend.delete();
      exp_q.delete();
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      last_was_alu = 1'b0;
      m_wr_valid   = 1'b0;
      m_wr_rd      = '0;
   endtask

   task automatic driveIdle();
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      bus.rs1         = '0;
      bus.rs2         = '0;
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = '0;
      bus.alu_data    = '0;
      bus.lsu_valid   = 1'b0;
      bus.lsu_rd      = '0;
      bus.lsu_data    = '0;
      flush           = 1'b0;
   endtask

   // One clock cycle of stimulus: drive inputs on the falling edge, check the
   // combinational responses against the model, then advance the model to the
   // state it will have after the next rising edge.
   task automatic applyStimulus(
      input bit iv, input logic [AW-1:0] ird,
      input logic [AW-1:0] r1, input logic [AW-1:0] r2,
      input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
      input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
      input bit fl);
      bit alu_has;
      bit lsu_has;
      int winner;
      bit e_issue_ready;
      bit e_hazard;
      bit e_alu_ready;
      bit e_lsu_ready;
      @(negedge clk);
      bus.issue_valid = iv;
      bus.issue_rd    = ird;
      bus.rs1         = r1;
      bus.rs2         = r2;
      bus.alu_valid   = av;
      bus.alu_rd      = ard;
      bus.alu_data    = ad;
      bus.lsu_valid   = lv;
      bus.lsu_rd      = lrd;
      bus.lsu_data    = ld;
      flush           = fl;
      #1;
      alu_has = (alu_pend.size() != 0);
      lsu_has = (lsu_pend.size() != 0);
      if (alu_has && lsu_has) winner = last_was_alu ? 2 : 1;
      else if (alu_has)       winner = 1;
      else if (lsu_has)       winner = 2;
      else                    winner = 0;
      e_issue_ready = !(ird != 0 && m_busy[ird]);
      e_hazard      = (r1 != 0 && m_busy[r1]) || (r2 != 0 && m_busy[r2]);
      e_alu_ready   = !alu_has || (winner == 1);
      e_lsu_ready   = !lsu_has || (winner == 2);
      checkOutput("issue_ready", bus.issue_ready, e_issue_ready);
      checkOutput("hazard", bus.hazard, e_hazard);
      checkOutput("alu_ready", bus.alu_ready, e_alu_ready);
      checkOutput("lsu_ready", bus.lsu_ready, e_lsu_ready);
      if (fl) begin
         for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
         alu_pend.delete();
         lsu_pend.delete();
         m_wr_valid = 1'b0;
      end else begin
         if (m_wr_valid) m_busy[m_wr_rd] = 1'b0;
         if (iv && e_issue_ready && ird != 0) m_busy[ird] = 1'b1;
         if (winner == 1) begin
            exp_q.push_back('{cyc + 1, alu_pend[0].rd, alu_pend[0].data});
            m_wr_rd = alu_pend[0].rd;
            void'(alu_pend.pop_front());
            m_wr_valid   = 1'b1;
            last_was_alu = 1'b1;
         end else if (winner == 2) begin
            exp_q.push_back('{cyc + 1, lsu_pend[0].rd, lsu_pend[0].data});
            m_wr_rd = lsu_pend[0].rd;
            void'(lsu_pend.pop_front());
            m_wr_valid   = 1'b1;
            last_was_alu = 1'b0;
         end else begin
            m_wr_valid = 1'b0;
         end
         if (av && e_alu_ready && ard != 0) alu_pend.push_back('{ard, ad});
         if (lv && e_lsu_ready && lrd != 0) lsu_pend.push_back('{lrd, ld});
      end
   endtask

   task automatic idle(input int n, input logic [AW-1:0] r1);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, r1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Scoreboard monitor: after each rising edge either the oldest expected
   // write is due now and must be on the port, or the port must be idle.
   initial begin : monitor
      wr_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0 && exp_q[0].stamp == cyc) begin
            e = exp_q.pop_front();
            checkOutput("rf_wen", bus.rf_wen, 1);
            checkOutput("rf_waddr", bus.rf_waddr, e.rd);
            checkOutput("rf_wdata", bus.rf_wdata, e.data);
         end else begin
            checkOutput("rf_wen_idle", bus.rf_wen, 0);
         end
      end
   end

   initial begin : stimulus
      logic [DW-1:0] d;
      driveIdle();
      modelReset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      bus.rs1 = 5;
      #1;
      checkOutput("reset_rf_wen", bus.rf_wen, 0);
      checkOutput("reset_rf_waddr", bus.rf_waddr, 0);
      checkOutput("reset_rf_wdata", bus.rf_wdata, 0);
      checkOutput("reset_hazard", bus.hazard, 0);
      checkOutput("reset_alu_ready", bus.alu_ready, 1);
      rst = 1'b1;

      $display("[TB] issue rd=5, hazard query, ALU writeback 0xDEADBEEF");
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      idle(4, 5);

      $display("[TB] simultaneous ALU and LSU writeback");
      applyStimulus(0, 0, 3, 4, 1, 3, 32'h11, 1, 4, 32'h22, 0);
      idle(4, 3);

      $display("[TB] both sources streaming for 6 cycles");
      for (int i = 0; i < 6; i++)
         applyStimulus(0, 0, 0, 0, 1, 5'(10 + i), $urandom, 1, 5'(20 + i), $urandom, 0);
      idle(4, 0);

      $display("[TB] WAW stall, x0 issue, x0 writeback");
      applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 7, 0, 0, 0, 1, 0, 32'hABCD, 0);
      applyStimulus(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0);
      idle(4, 7);

      $display("[TB] flush with full buffers");
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 2, 1, 2, 1, 1, 32'h101, 1, 2, 32'h202, 0);
      applyStimulus(0, 0, 1, 2, 1, 1, 32'h111, 1, 2, 32'h222, 0);
      applyStimulus(1, 3, 1, 2, 1, 6, 32'h666, 1, 6, 32'h606, 1);
      idle(4, 1);
      applyStimulus(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++)
         applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 24) == 0));
      idle(4, 0);

      $display("[TB] asynchronous reset with a write on the port");
      d = $urandom;
      applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 9, 0, 1, 9, d, 0, 0, 0, 0);
      applyStimulus(0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      checkOutput("pre_reset_rf_wen", bus.rf_wen, 1);
      checkOutput("pre_reset_hazard", bus.hazard, 1);
      rst = 1'b0;
      #1;
      checkOutput("async_reset_rf_wen", bus.rf_wen, 0);
      checkOutput("async_reset_rf_waddr", bus.rf_waddr, 0);
      checkOutput("async_reset_rf_wdata", bus.rf_wdata, 0);
      checkOutput("async_reset_hazard", bus.hazard, 0);
      modelReset();
      driveIdle();
      @(negedge clk);
      rst = 1'b1;
      idle(3, 9);

      for (int i = 0; i < 100; i++)
         applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), $urandom,
                       1'b0);
      idle(6, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the single register-file write port between the ALU/CSR writeback source and the LSU writeback source.
- Keeps a busy-bit scoreboard of destination registers with outstanding writes, so issue logic can stall on RAW/WAW hazards.
- Sits between EXU/LSU and the register file. Drives the register file's wen/waddr/wdata from registered outputs.

Parameters:
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low (rst==0 resets).
- flush  input  1  pipeline flush; clears scoreboard and pending writes.
- issue_valid  input  1  instruction issuing with a destination register.
- issue_rd  input  ADDR_WIDTH  destination register of the issuing instruction.
- issue_ready  output  1  issue accepted (no WAW conflict on issue_rd).
- rs1  input  ADDR_WIDTH  source register 1 for hazard query.
- rs2  input  ADDR_WIDTH  source register 2 for hazard query.
- hazard  output  1  rs1 or rs2 has a pending write.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU writeback accepted.
- alu_rd  input  ADDR_WIDTH  ALU destination.
- alu_data  input  DATA_WIDTH  ALU result.
- lsu_valid  input  1  LSU writeback request.
- lsu_ready  output  1  LSU writeback accepted.
- lsu_rd  input  ADDR_WIDTH  LSU destination.
- lsu_data  input  DATA_WIDTH  LSU load data.
- rf_wen  output  1  register-file write enable (registered).
- rf_waddr  output  ADDR_WIDTH  register-file write address (registered).
- rf_wdata  output  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset (rst==0, asynchronous):
  - busy[] all 0; both holding buffers empty.
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - last_grant=LSU, so the ALU wins the first tie.
- Scoreboard:
  - issue_ready = !(issue_rd!=0 && busy[issue_rd]).
  - On issue_valid && issue_ready && issue_rd!=0: set busy[issue_rd].
  - On every posedge with rf_wen==1: clear busy[rf_waddr]. This is the same edge the register file writes, so no stale-read window.
  - Set and clear of the same index on one edge cannot occur, because issue_ready is 0 while the bit is set. If different indices, both take effect.
  - hazard = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]). Combinational from busy[] only; no bypass.
- Holding buffers (one entry each, per source):
  - x_ready = !x_full || grant_x. A granted entry drains in the same cycle a new one is accepted, giving 1 write/cycle throughput.
  - Handshake x_valid && x_ready loads {rd, data} into the buffer.
  - A request with rd==0 is accepted (ready as above) and discarded; the buffer is not loaded, and an existing entry is unaffected.
- Arbitration (combinational from full flags and last_grant):
  - Only one buffer full: grant it.
  - Both full: grant the source that is not last_grant.
  - On a grant at posedge:
    - rf_wen<=1, rf_waddr<=rd, rf_wdata<=data.
    - The buffer empties unless refilled on the same edge.
    - last_grant<=granted source.
  - No grant: rf_wen<=0; rf_waddr and rf_wdata hold their values.
- Latency: handshake at edge E, rf_wen high in cycle after E+1, register file written at E+2. Back-to-back from one source sustains 1 write/cycle.
- Flush (synchronous, highest priority):
  - Clears busy[] and both buffers; rf_wen<=0.
  - Handshakes and issue on the flush cycle are ignored, but ready/issue_ready are still computed normally.
  - A write already in rf_wen during the flush cycle still lands in the register file.
- Reset asserted mid-operation: all state returns to reset values immediately. No write is issued after deassertion until a new handshake.

Test Plan:
- After reset: issue rd=5 → busy[5]=1; rs1=5 → hazard=1. ALU writeback rd=5, data=0xDEADBEEF → rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF two edges after the handshake. hazard drops after that edge.
- ALU and LSU both valid in the same cycle (rd=3 data=0x11, rd=4 data=0x22) → ALU written first, LSU on the next cycle. alu_ready and lsu_ready are both 1 on the accept cycle.
- Both sources continuously valid for 6 cycles → grants strictly alternate ALU/LSU; rf_wen stays high every cycle after the first.
- Issue rd=7 while busy[7]=1 → issue_ready=0. Issue rd=0 → issue_ready=1 and busy unchanged. LSU writeback rd=0 → accepted, rf_wen stays 0.
- Buffers full and busy[1,2]=1, assert flush → next cycle: busy all 0, rf_wen=0, no pending writes emitted afterwards.
- Drive rst=0 mid-stream with rf_wen=1 → rf_wen, rf_waddr and rf_wdata go to 0 without waiting for a clock edge; busy cleared.
